// File: rtl/aes_stream_pkg.sv
// aes_stream_pkg: shared state encoding and block geometry for the AES byte stream wrapper
package aes_stream_pkg;
  localparam int BLOCK_BYTES = 16;
  localparam int BYTE_CNT_W = 4;
  typedef enum logic [2:0] {LOAD_KEY, LOAD_PT, START, WAIT, SEND} state_t;
endpackage

// File: rtl/aes_shift_reg128.sv
// aes_shift_reg128: 128-bit MSB-first byte shift register with parallel load
module aes_shift_reg128 (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic [7:0]   din,
  input  logic [127:0] load_data,
  output logic [127:0] q
);
  // load wins over shift; shifting moves bytes toward [127:120] so the first byte ends up on top
  always_ff @(posedge clk)
    if (rst) q <= '0;
    else if (load) q <= load_data;
    else if (shift) q <= {q[119:0], din};
endmodule

// File: rtl/aes_byte_stream.sv
// aes_byte_stream: byte-serial key/plaintext loader and ciphertext unloader around an AES core
module aes_byte_stream import aes_stream_pkg::*; #(
  parameter int CORE_LATENCY = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [7:0]   in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [7:0]   out_data,
  output logic         out_last,
  input  logic         out_ready,
  output logic         core_en,
  output logic [127:0] core_plaintext,
  output logic [127:0] core_key,
  input  logic [127:0] core_ciphertext,
  output logic         busy
);
  state_t state;
  logic [BYTE_CNT_W-1:0] cnt, wcnt;
  logic in_acc, out_acc, cap, last_byte, unused_ct;
  logic [127:0] ct_q;
  assign in_ready = state == LOAD_KEY || state == LOAD_PT;
  assign out_valid = state == SEND;
  assign core_en = state == START;
  assign in_acc = in_valid && in_ready;
  assign out_acc = out_valid && out_ready;
  assign last_byte = cnt == BYTE_CNT_W'(BLOCK_BYTES - 1);
  assign cap = state == WAIT && wcnt == BYTE_CNT_W'(CORE_LATENCY - 1);
  assign out_data = ct_q[127:120];
  assign out_last = out_valid && last_byte;
  assign busy = !(state == LOAD_KEY && cnt == '0);
  assign unused_ct = ^ct_q[119:0];
  // block sequencer: byte counter shared by load and send phases, wait counter times the core
  always_ff @(posedge clk)
    if (rst) begin
      state <= LOAD_KEY;
      cnt <= '0;
      wcnt <= '0;
    end else
      case (state)
        LOAD_KEY: if (in_acc) begin
          cnt <= cnt + 1'b1;
          if (last_byte) state <= LOAD_PT;
        end
        LOAD_PT: if (in_acc) begin
          cnt <= cnt + 1'b1;
          if (last_byte) state <= START;
        end
        START: begin
          wcnt <= '0;
          state <= WAIT;
        end
        WAIT: if (cap) state <= SEND;
              else wcnt <= wcnt + 1'b1;
        SEND: if (out_acc) begin
          cnt <= cnt + 1'b1;
          if (last_byte) state <= LOAD_KEY;
        end
        default: state <= LOAD_KEY;
      endcase
  aes_shift_reg128 u_key (
    .clk(clk), .rst(rst), .load(1'b0), .shift(in_acc && state == LOAD_KEY),
    .din(in_data), .load_data('0), .q(core_key)
  );
  aes_shift_reg128 u_pt (
    .clk(clk), .rst(rst), .load(1'b0), .shift(in_acc && state == LOAD_PT),
    .din(in_data), .load_data('0), .q(core_plaintext)
  );
  aes_shift_reg128 u_ct (
    .clk(clk), .rst(rst), .load(cap), .shift(out_acc),
    .din(8'h00), .load_data(core_ciphertext), .q(ct_q)
  );
endmodule

// File: doc/aes_byte_stream.md
AES_BYTE_STREAM -- requirements
Module: aes_byte_stream

Interface
REQ-001 SHALL have parameter: CORE_LATENCY, 2, cycles from the core_en cycle to the cycle whose ending edge captures core_ciphertext; legal values 1..15.
REQ-002 SHALL use one clock and a synchronous, active-high reset: clk input, rst synchronous active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 in_valid  input  1  input byte valid.
REQ-006 in_data  input  8  input byte.
REQ-007 in_ready  output  1  byte accepted when in_valid && in_ready.
REQ-008 out_valid  output  1  output byte valid.
REQ-009 out_data  output  8  ciphertext byte.
REQ-010 out_last  output  1  high with the 16th ciphertext byte.
REQ-011 out_ready  input  1  downstream accepts when out_valid && out_ready.
REQ-012 core_en  output  1  single-cycle start pulse to aes_simple_top en.
REQ-013 core_plaintext  output  128  to aes_simple_top plaintext.
REQ-014 core_key  output  128  to aes_simple_top key.
REQ-015 core_ciphertext  input  128  from aes_simple_top ciphertext.
REQ-016 busy  output  1  high in every state except LOAD_KEY with byte count 0.

Function
REQ-017 SHALL implement states LOAD_KEY, LOAD_PT, START, WAIT, SEND.
REQ-018 A block is 32 input bytes: 16 key bytes, then 16 plaintext bytes; the first byte of each field maps to bits [127:120] (MSB first).
REQ-019 in_ready SHALL be 1 only in LOAD_KEY and LOAD_PT; bytes presented at other times are not consumed.
REQ-020 Byte counter: 4 bits, increments per accepted byte, wraps 15->0 on the 16th byte; LOAD_KEY->LOAD_PT and LOAD_PT->START occur on that wrap.
REQ-021 in_valid gaps SHALL stall the counter; no byte lost or duplicated.
REQ-022 START lasts exactly one cycle with core_en=1; core_en SHALL be 0 in all other states.
REQ-023 WAIT counts CORE_LATENCY-1 further cycles; core_ciphertext is captured on the edge ending cycle T+CORE_LATENCY (T = START cycle); SEND is entered in cycle T+CORE_LATENCY+1.
REQ-024 core_key/core_plaintext SHALL be stable from START until after capture; they change only on accepted bytes.
REQ-025 SEND: out_valid=1, out_data = captured ciphertext bits [127:120] first; the next byte advances only on out_ready; out_data/out_last are held while out_ready=0.
REQ-026 After the 16th accepted output byte (out_last=1): out_valid=0 next cycle, state LOAD_KEY, counter 0.
REQ-027 Minimum block period with no stalls: 32 + 1 + CORE_LATENCY + 16 cycles.

Reset
REQ-028 rst SHALL force state LOAD_KEY, counters 0, in_ready=1, out_valid=0, out_last=0, out_data=0, core_en=0, core_key=0, core_plaintext=0, ciphertext register=0.
REQ-029 rst asserted in any state, including mid-load, WAIT, or SEND, SHALL discard the partial block; the first byte accepted after reset is key byte 0.
REQ-030 rst asserted in the same cycle as an input or output handshake SHALL take priority; that byte is not counted.

Structure
REQ-031 Package aes_stream_pkg SHALL hold the state enum typedef, BLOCK_BYTES=16 and BYTE_CNT_W=4.
REQ-032 Sub-module aes_shift_reg128 (128-bit MSB-first byte shift register with load/shift enables) SHALL be instantiated three times: key, plaintext, ciphertext.

Verification
REQ-033 FIPS-197 C.1: key 000102...0f, pt 00112233445566778899aabbccddeeff -> out bytes 69 c4 e0 d8 6a 7b 04 30 d8 cd b7 80 70 b4 c5 5a, out_last on 5a.
REQ-034 FIPS-197 B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734, random in_valid gaps -> 39 25 84 1d ... 0b 32.
REQ-035 out_ready low for 5 cycles at byte 7 -> out_data held at byte 7, no byte skipped, 16 bytes total.
REQ-036 rst pulse after 20 input bytes, then full vector C.1 -> correct C.1 ciphertext; no core_en before the reset-recovered block.
REQ-037 Two back-to-back blocks -> exactly one core_en per block; core_en in cycle 33 of continuous input; in_ready=0 from START until last out byte.
REQ-038 CORE_LATENCY=1 and 4 -> capture timing per REQ-023, outputs unchanged.
